instruction_fetch: RTL and testbench

- IF stage of the 5-stage MIPS pipeline; sits directly upstream of instruction_decode.
- Holds the PC, a word-addressed instruction memory, and the IF/ID pipeline register.
- Feeds instruction_decode with `o_instruction` and `o_pc` (PC+4 of the fetched word). Consumes its combinational jump outputs, the hazard-unit stall and the debug-unit halt.
- Instruction memory is loaded by the debug unit through a write port while the stage is idle.

---
 rtl/instruction_fetch.sv | 109 ++++++++++
 tb/tb_instruction_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC, word-addressed instruction memory
// with a debug load port, and the IF/ID pipeline register feeding instruction_decode.
module instruction_fetch #(
  parameter int ADDR_W     = 8,
  parameter int IMEM_DEPTH = 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_halt,
  input  logic              i_stall,
  input  logic              i_jump,
  input  logic [31:0]       i_jump_address,
  input  logic              i_imem_we,
  input  logic [ADDR_W-1:0] i_imem_addr,
  input  logic [31:0]       i_imem_data,
  output logic [31:0]       o_instruction,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_current_pc,
  output logic              o_running,
  output logic              o_done
);

  localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        running_q;
  logic        done_q;

  logic [31:0] mem [IMEM_DEPTH];

  logic [31:0] fetched_word;
  logic [31:0] pc_plus4_d;
  logic [31:0] jump_target_d;
  logic        advance_d;

  // Upper PC bits are dropped so fetch addresses wrap around the memory.
  assign fetched_word  = mem[pc_q[ADDR_W+1:2]];
  assign pc_plus4_d    = pc_q + 32'd4;
  assign jump_target_d = i_jump_address & ~32'h3;
  assign advance_d     = !i_halt && !i_stall;

  // Program loading is only accepted while the stage is idle.
  always_ff @(posedge i_clk) begin
    if (i_imem_we && state_q == IDLE) begin
      mem[i_imem_addr] <= i_imem_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      pc_q      <= 32'd0;
      instr_q   <= 32'd0;
      pc4_q     <= 32'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start && !i_halt) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (advance_d) begin
            instr_q <= fetched_word;
            pc4_q   <= pc_plus4_d;
            // END beats a same-cycle jump: PC freezes on the END word.
            if (fetched_word == END_WORD) begin
              state_q   <= DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (i_jump) begin
              pc_q <= jump_target_d;
            end else begin
              pc_q <= pc_plus4_d;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_instruction = instr_q;
  assign o_pc          = pc4_q;
  assign o_current_pc  = pc_q;
  assign o_running     = running_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a default-size instance for program
// flow, jumps, stalls, halts and write protection, and a 4-word instance for wrap.
module tb_instruction_fetch;

  localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_halt, i_stall, i_jump, i_imem_we;
  logic [31:0] i_jump_address, i_imem_data;
  logic [7:0]  i_imem_addr;
  logic [31:0] o_instruction, o_pc, o_current_pc;
  logic        o_running, o_done;

  logic        w_reset, w_start, w_we;
  logic [1:0]  w_addr;
  logic [31:0] w_data, w_instr, w_pc, w_cur;
  logic        w_run, w_done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [256];
  logic [31:0] model_pc;
  logic        model_done;
  exp_t        exp_q [$];

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(8)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_halt(i_halt),
    .i_stall(i_stall), .i_jump(i_jump), .i_jump_address(i_jump_address),
    .i_imem_we(i_imem_we), .i_imem_addr(i_imem_addr), .i_imem_data(i_imem_data),
    .o_instruction(o_instruction), .o_pc(o_pc), .o_current_pc(o_current_pc),
    .o_running(o_running), .o_done(o_done)
  );

  instruction_fetch #(.ADDR_W(2)) dut_wrap (
    .i_clk(clk), .i_reset(w_reset), .i_start(w_start), .i_halt(1'b0),
    .i_stall(1'b0), .i_jump(1'b0), .i_jump_address(32'd0),
    .i_imem_we(w_we), .i_imem_addr(w_addr), .i_imem_data(w_data),
    .o_instruction(w_instr), .o_pc(w_pc), .o_current_pc(w_cur),
    .o_running(w_run), .o_done(w_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    model_pc   = 32'd0;
    model_done = 1'b0;
    exp_q.delete();
    check("rst_cur_pc", o_current_pc, 32'd0);
    check("rst_instr", o_instruction, 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_running", 32'(o_running), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    i_imem_we   = 1'b1;
    i_imem_addr = 8'(addr);
    i_imem_data = data;
    tick();
    i_imem_we = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_running", 32'(o_running), 32'd1);
  endtask

  // One advancing fetch cycle: predict, clock, then compare against the scoreboard.
  task automatic adv(input logic jmp, input logic [31:0] jaddr);
    exp_t e;
    i_jump = jmp;
    i_jump_address = jaddr;
    if (!model_done) begin
      e.instr = model_mem[model_pc[9:2]];
      e.pc    = model_pc + 32'd4;
      exp_q.push_back(e);
      if (e.instr == END_WORD) model_done = 1'b1;
      else if (jmp) model_pc = {jaddr[31:2], 2'b00};
      else model_pc = model_pc + 32'd4;
    end
    tick();
    i_jump = 1'b0;
    $display("[TB] fetch instr=%h pc=%h cur_pc=%h", o_instruction, o_pc, o_current_pc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("instr", o_instruction, e.instr);
      check("pc", o_pc, e.pc);
    end
    check("cur_pc", o_current_pc, model_pc);
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h2001_0005;
    prog[1] = 32'h2002_0007;
    prog[2] = 32'h0000_0000;
    prog[3] = END_WORD;
    i_reset = 1'b0; i_start = 1'b0; i_halt = 1'b0; i_stall = 1'b0; i_jump = 1'b0;
    i_imem_we = 1'b0; i_imem_addr = '0; i_imem_data = '0; i_jump_address = '0;
    w_reset = 1'b0; w_start = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    model_pc = '0; model_done = 1'b0;

    // Load and run to END
    do_reset();
    for (int i = 0; i < 4; i++) load(i, prog[i]);
    start_pulse();
    repeat (4) adv(1'b0, 32'd0);
    check("end_done", 32'(o_done), 32'd1);
    check("end_pc4", o_pc, 32'd16);
    check("end_cur_pc", o_current_pc, 32'd12);
    tick();
    check("end_hold_instr", o_instruction, END_WORD);
    check("end_hold_pc", o_current_pc, 32'd12);

    // Jump with delay slot
    do_reset();
    for (int i = 0; i < 32; i++) load(i, 32'h1000_0000 + 32'(i));
    start_pulse();
    repeat (2) adv(1'b0, 32'd0);
    adv(1'b1, 32'h40);
    check("slot_instr", o_instruction, 32'h1000_0002);
    check("slot_pc", o_pc, 32'd12);
    adv(1'b0, 32'd0);
    check("target_instr", o_instruction, 32'h1000_0010);
    check("target_pc", o_pc, 32'h44);

    // Stall beats jump
    do_reset();
    start_pulse();
    repeat (4) adv(1'b0, 32'd0);
    i_stall = 1'b1; i_jump = 1'b1; i_jump_address = 32'h80;
    repeat (2) tick();
    check("stall_cur_pc", o_current_pc, 32'h10);
    check("stall_instr", o_instruction, 32'h1000_0003);
    check("stall_pc", o_pc, 32'd16);
    i_stall = 1'b0;
    adv(1'b1, 32'h20);

    // Halt freezes everything, even with a jump pending
    i_halt = 1'b1; i_jump = 1'b1; i_jump_address = 32'h60;
    repeat (5) tick();
    check("halt_cur_pc", o_current_pc, 32'h20);
    check("halt_instr", o_instruction, 32'h1000_0004);
    check("halt_pc", o_pc, 32'h14);
    check("halt_running", 32'(o_running), 32'd1);
    i_halt = 1'b0; i_jump = 1'b0;
    adv(1'b0, 32'd0);
    check("resume_instr", o_instruction, 32'h1000_0008);
    adv(1'b1, 32'h43);
    check("unaligned_jump", o_current_pc, 32'h40);

    // Write protection in RUN, then write-with-start in IDLE
    i_imem_we = 1'b1; i_imem_addr = 8'd3; i_imem_data = 32'hDEAD_BEEF;
    adv(1'b0, 32'd0);
    i_imem_we = 1'b0;
    do_reset();
    start_pulse();
    repeat (4) adv(1'b0, 32'd0);
    check("wp_instr", o_instruction, 32'h1000_0003);
    do_reset();
    i_imem_we = 1'b1; i_imem_addr = 8'd3; i_imem_data = 32'hDEAD_BEEF; i_start = 1'b1;
    tick();
    i_imem_we = 1'b0; i_start = 1'b0;
    model_mem[3] = 32'hDEAD_BEEF;
    check("we_start_running", 32'(o_running), 32'd1);
    repeat (4) adv(1'b0, 32'd0);
    check("idle_write_instr", o_instruction, 32'hDEAD_BEEF);

    // END fetched together with a jump
    do_reset();
    load(5, END_WORD);
    start_pulse();
    repeat (5) adv(1'b0, 32'd0);
    adv(1'b1, 32'h80);
    check("endjmp_done", 32'(o_done), 32'd1);
    check("endjmp_cur_pc", o_current_pc, 32'd20);

    // Address wrap on a 4-word memory, then reset mid-run
    w_reset = 1'b1; tick(); w_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_we = 1'b1; w_addr = 2'(i); w_data = 32'hA0 + 32'(i);
      tick();
    end
    w_we = 1'b0;
    w_start = 1'b1; tick(); w_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      $display("[TB] wrap fetch instr=%h pc=%h", w_instr, w_pc);
      check("wrap_instr", w_instr, 32'hA0 + 32'(k % 4));
      check("wrap_pc", w_pc, 32'(4 * (k + 1)));
    end
    w_reset = 1'b1; tick(); w_reset = 1'b0;
    check("wrap_rst_cur", w_cur, 32'd0);
    check("wrap_rst_instr", w_instr, 32'd0);
    check("wrap_rst_running", 32'(w_run), 32'd0);
    check("wrap_rst_done", 32'(w_done), 32'd0);
    w_start = 1'b1; tick(); w_start = 1'b0;
    tick();
    check("wrap_rerun_instr", w_instr, 32'hA0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
